// File: rtl/spi_ctrl_tx.sv
// SPI mode-0 initiator that sends 16-bit frames {wr, addr[6:0], data[7:0]} MSB first.
// Define SPI_CTRL_READBACK_EN to add rnw/miso/rdata for register reads.
module spi_ctrl_tx #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
`ifdef SPI_CTRL_READBACK_EN
  input  logic       miso,
  input  logic       rnw,
  output logic [7:0] rdata,
`endif
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi
);

  // state | meaning
  // IDLE  | waiting for start, all pins idle
  // LEAD  | cs_n low, first bit on mosi, sclk held low for CLK_DIV cycles
  // SHIFT | sclk toggles every CLK_DIV cycles, 16 rising edges
  // TRAIL | sclk low, cs_n still low for CLK_DIV cycles
  // GAP   | cs_n high for GAP_CYCLES cycles before done
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_TRAIL,
    S_GAP
  } state_t;

  localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_TC = 8'(GAP_CYCLES - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [14:0] shift_q;   // frame bits 14..0; bit 15 goes straight to mosi on accept
  logic        div_tc;
  logic        gap_tc;
  logic        wr_flag;

  assign div_tc = (div_cnt == DIV_TC);
  assign gap_tc = (div_cnt == GAP_TC);

`ifdef SPI_CTRL_READBACK_EN
  logic       rnw_q;
  logic [7:0] rx_q;
  assign wr_flag = ~rnw;
`else
  assign wr_flag = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      div_cnt <= 8'd0;
      bit_cnt <= 5'd0;
      shift_q <= 15'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
`ifdef SPI_CTRL_READBACK_EN
      rnw_q   <= 1'b0;
      rx_q    <= 8'd0;
      rdata   <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          div_cnt <= 8'd0;
          bit_cnt <= 5'd0;
          if (start) begin
            shift_q <= {addr, wdata};
            mosi    <= wr_flag;
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            state   <= S_LEAD;
`ifdef SPI_CTRL_READBACK_EN
            rnw_q   <= rnw;
`endif
          end
        end

        // The lead-in terminal count produces the first sclk rise (k=0).
        S_LEAD: begin
          if (div_tc) begin
            div_cnt <= 8'd0;
            sclk    <= 1'b1;
            state   <= S_SHIFT;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        S_SHIFT: begin
          if (div_tc) begin
            div_cnt <= 8'd0;
            sclk    <= ~sclk;
            if (sclk) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd15) begin
                mosi  <= 1'b0;
                state <= S_TRAIL;
              end else begin
                mosi    <= shift_q[14];
                shift_q <= {shift_q[13:0], 1'b0};
              end
            end
`ifdef SPI_CTRL_READBACK_EN
            else if (bit_cnt[3]) begin
              // bit_cnt equals the rise index here; rises 8..15 carry read data
              rx_q <= {rx_q[6:0], miso};
            end
`endif
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        S_TRAIL: begin
          if (div_tc) begin
            div_cnt <= 8'd0;
            cs_n    <= 1'b1;
            state   <= S_GAP;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        S_GAP: begin
          if (gap_tc) begin
            div_cnt <= 8'd0;
            bit_cnt <= 5'd0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
`ifdef SPI_CTRL_READBACK_EN
            if (rnw_q) rdata <= rx_q;
`endif
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          sclk  <= 1'b0;
          cs_n  <= 1'b1;
          mosi  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ctrl_tx.sv
// Self-checking bench for spi_ctrl_tx: scoreboard of expected frames checked by a pin monitor.
`timescale 1ns/1ps
module tb_spi_ctrl_tx;
  localparam int CLK_DIV    = 4;
  localparam int GAP_CYCLES = 4;
  localparam int CS_LOW     = 33 * CLK_DIV;
  localparam int DONE_LAT   = 33 * CLK_DIV + GAP_CYCLES;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] addr  = 7'd0;
  logic [7:0] wdata = 8'd0;
  logic       busy, done, sclk, cs_n, mosi;
`ifdef SPI_CTRL_READBACK_EN
  logic       miso = 1'b0;
  logic       rnw  = 1'b0;
  logic [7:0] rdata;
  logic [7:0] resp = 8'h5A;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  spi_ctrl_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .addr  (addr),
    .wdata (wdata),
`ifdef SPI_CTRL_READBACK_EN
    .miso  (miso),
    .rnw   (rnw),
    .rdata (rdata),
`endif
    .busy  (busy),
    .done  (done),
    .sclk  (sclk),
    .cs_n  (cs_n),
    .mosi  (mosi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pin monitor: reassembles frames from sclk rises and checks them against the scoreboard.
  int rises = 0, trans = 0, falls = 0, cs_low = 0, cs_high = 0;
  int last_gap = -1, frames = 0, done_cnt = 0;
  logic [15:0] cap = 16'd0;
  logic [15:0] exp_frame;
  logic sclk_d = 1'b0, cs_d = 1'b1, mosi_d = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rises = 0; trans = 0; falls = 0; cs_low = 0; cs_high = 0; cap = 16'd0;
`ifdef SPI_CTRL_READBACK_EN
      miso = 1'b0;
`endif
    end else begin
      if (done === 1'b1) done_cnt++;
      if (!cs_n && cs_d) begin
        last_gap = cs_high;
        cs_high = 0; rises = 0; trans = 0; falls = 0; cs_low = 0; cap = 16'd0;
      end
      if (sclk !== sclk_d) trans++;
      if (!sclk && sclk_d) begin
        falls++;
`ifdef SPI_CTRL_READBACK_EN
        miso = (falls >= 8 && falls <= 15) ? resp[15 - falls] : 1'b0;
`endif
      end
      if (sclk && !sclk_d) begin
        rises++;
        cap = {cap[14:0], mosi};
        checks++;
        if (mosi !== mosi_d) begin
          errors++;
          $display("FAIL mosi_stable: rise %0d mosi=%b, held value before rise=%b", rises, mosi, mosi_d);
        end
      end
      if (cs_n) cs_high++;
      else cs_low++;
      if (cs_n && !cs_d) begin
        frames++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected: got frame %h, expected no frame", cap);
        end else begin
          exp_frame = exp_q.pop_front();
          if (cap !== exp_frame) begin
            errors++;
            $display("FAIL frame_bits: got %h, expected %h", cap, exp_frame);
          end
        end
        checks++;
        if (rises != 16 || trans != 32) begin
          errors++;
          $display("FAIL sclk_edges: got %0d rises/%0d transitions, expected 16/32", rises, trans);
        end
        checks++;
        if (cs_low != CS_LOW) begin
          errors++;
          $display("FAIL cs_low_len: got %0d cycles, expected %0d", cs_low, CS_LOW);
        end
      end
    end
`ifdef SPI_CTRL_READBACK_EN
    if (cs_n) miso = 1'b0;
`endif
    sclk_d = sclk; cs_d = cs_n; mosi_d = mosi;
  end

  task automatic drive_start(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wdata = d; start = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    int n;
    n = 0; seen = 1'b0;
    while (n < limit) begin
      @(posedge clk); #1; n++;
      if (done === 1'b1) begin seen = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, sclk, cs_n, mosi} !== 5'b00010) begin
      errors++;
      $display("FAIL reset_hold: outputs busy,done,sclk,cs_n,mosi=%b, expected 00010", {busy, done, sclk, cs_n, mosi});
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, done, sclk, cs_n, mosi} !== 5'b00010) begin
        errors++;
        $display("FAIL reset_idle: cycle %0d outputs=%b, expected 00010", i, {busy, done, sclk, cs_n, mosi});
      end
    end
  endtask

  task automatic test_single_write();
    int acc, f0;
    bit seen;
    f0 = frames;
    exp_q.push_back(16'h83A5);
    drive_start(7'd3, 8'hA5);
    acc = cyc;
    checks++;
    if ({busy, cs_n, mosi} !== 3'b101) begin
      errors++;
      $display("FAIL accept_pins: busy,cs_n,mosi=%b, expected 101", {busy, cs_n, mosi});
    end
    @(negedge clk) start = 1'b0;
    wait_done(400, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL single_done_timeout: done seen=0, expected 1");
    end else begin
      checks++;
      if (cyc - acc != DONE_LAT || busy !== 1'b0) begin
        errors++;
        $display("FAIL single_done_lat: latency %0d busy=%b, expected %0d busy=0", cyc - acc, busy, DONE_LAT);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || frames - f0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_after: done=%b frames=%0d pending=%0d, expected 0/1/0", done, frames - f0, exp_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    int f0, d0;
    bit seen;
    f0 = frames; d0 = done_cnt;
    exp_q.push_back(16'h9042);
    drive_start(7'h10, 8'h42);
    @(negedge clk) start = 1'b0;
    repeat (48) @(negedge clk);
    addr = 7'd5; wdata = 8'h11; start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(400, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL busy_done_timeout: done seen=0, expected 1");
    end
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - d0 != 1 || frames - f0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL busy_ignore: dones=%0d frames=%0d pending=%0d, expected 1/1/0", done_cnt - d0, frames - f0, exp_q.size());
    end
    checks++;
    if ({busy, cs_n} !== 2'b01) begin
      errors++;
      $display("FAIL busy_idle_after: busy,cs_n=%b, expected 01", {busy, cs_n});
    end
  endtask

  task automatic test_back_to_back();
    int f0;
    bit seen;
    f0 = frames;
    exp_q.push_back(16'h81FF);
    drive_start(7'd1, 8'hFF);
    @(negedge clk);
    addr = 7'd2; wdata = 8'h00;
    exp_q.push_back(16'h8200);
    wait_done(400, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL b2b_first_timeout: done seen=0, expected 1");
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, cs_n, mosi} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_reaccept: busy,cs_n,mosi=%b one cycle after done, expected 101", {busy, cs_n, mosi});
    end
    @(negedge clk) start = 1'b0;
    wait_done(400, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL b2b_second_timeout: done seen=0, expected 1");
    end
    @(posedge clk); #1;
    checks++;
    if (last_gap != GAP_CYCLES + 1 || frames - f0 != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_gap: gap=%0d frames=%0d pending=%0d, expected %0d/2/0", last_gap, frames - f0, exp_q.size(), GAP_CYCLES + 1);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, f0;
    bit seen;
    drive_start(7'd9, 8'h77);
    @(negedge clk) start = 1'b0;
    n = 0;
    while (rises < 7 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (rises < 7) begin
      errors++;
      $display("FAIL midrst_rises_timeout: rises=%0d, expected 7", rises);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sclk, cs_n, mosi} !== 5'b00010) begin
      errors++;
      $display("FAIL midrst_async: outputs=%b, expected 00010", {busy, done, sclk, cs_n, mosi});
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, sclk, cs_n, mosi} !== 5'b00010) begin
      errors++;
      $display("FAIL midrst_no_resume: outputs=%b, expected 00010", {busy, done, sclk, cs_n, mosi});
    end
    f0 = frames;
    exp_q.push_back(16'h843C);
    drive_start(7'd4, 8'h3C);
    @(negedge clk) start = 1'b0;
    wait_done(400, seen);
    checks++;
    if (!seen || frames - f0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_next_frame: done=%b frames=%0d pending=%0d, expected 1/1/0", seen, frames - f0, exp_q.size());
    end
  endtask

`ifdef SPI_CTRL_READBACK_EN
  task automatic test_readback();
    bit seen;
    resp = 8'h5A;
    rnw = 1'b1;
    exp_q.push_back(16'h0200);
    drive_start(7'd2, 8'h00);
    @(negedge clk) begin start = 1'b0; rnw = 1'b0; end
    wait_done(400, seen);
    checks++;
    if (!seen || rdata !== 8'h5A) begin
      errors++;
      $display("FAIL readback_data: done=%b rdata=%h, expected 1/5a", seen, rdata);
    end
    @(posedge clk); #1;
    resp = 8'hC3;
    exp_q.push_back(16'h8811);
    drive_start(7'd8, 8'h11);
    @(negedge clk) start = 1'b0;
    wait_done(400, seen);
    checks++;
    if (!seen || rdata !== 8'h5A || exp_q.size() != 0) begin
      errors++;
      $display("FAIL readback_hold: done=%b rdata=%h pending=%0d, expected 1/5a/0", seen, rdata, exp_q.size());
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef SPI_CTRL_READBACK_EN
    test_readback();
`endif
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ctrl_tx.md
Name: spi_ctrl_tx

Overview:
- SPI controller (initiator) that drives 16-bit write frames into the team's SPI peripheral register file.
- Frame layout, MSB first: {1'b1 write flag, addr[6:0], data[7:0]}.
- Generates sclk, cs_n and mosi from the system clock. Mode 0: mosi changes on sclk falling edge and is sampled by the peripheral on the rising edge; sclk idles low.
- Sits between the local command logic (start/addr/data handshake) and the chip SPI pins.

Parameters:
- CLK_DIV, 4, sclk half-period in clk cycles; legal range 2..255.
- GAP_CYCLES, 4, minimum clk cycles cs_n stays high after a frame before done/idle; legal 1..255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse/level; sampled only when busy=0.
- addr  input  7  target register address; latched on accept.
- wdata  input  8  write data; latched on accept.
- busy  output  1  high from accept through end of gap.
- done  output  1  one-cycle pulse at frame completion.
- sclk  output  1  SPI clock, idle 0.
- cs_n  output  1  chip select, active low, idle 1.
- mosi  output  1  serial data out, idle 0.

Behaviour:
- All outputs are registered.
- Reset (async, any time, including mid-frame):
  - busy=0, done=0, sclk=0, cs_n=1, mosi=0.
  - FSM=IDLE; divider, bit counter and shift register cleared.
  - A partial frame is abandoned and nothing is resumed.
- States: IDLE -> LEAD -> SHIFT -> TRAIL -> GAP -> IDLE.
- IDLE:
  - On the posedge (call it N) with start=1, latch frame={1'b1,addr,wdata}.
  - After edge N: busy=1, cs_n=0, mosi=frame[15]. Go to LEAD.
  - start while busy=1 is ignored; there is no queueing.
- LEAD: hold for CLK_DIV cycles, then enter SHIFT.
- SHIFT:
  - Divider counts 0..CLK_DIV-1 and toggles sclk at terminal count.
  - sclk rises after edges N+(2k+1)*CLK_DIV and falls after N+(2k+2)*CLK_DIV, for k=0..15. That is exactly 16 rising edges.
  - On falls k=0..14, mosi<=frame[14-k].
  - On fall k=15, mosi<=0 and go to TRAIL.
- TRAIL: hold cs_n=0, sclk=0 for CLK_DIV cycles; cs_n<=1 after edge N+33*CLK_DIV. Go to GAP.
- GAP:
  - Count GAP_CYCLES cycles.
  - After edge N+33*CLK_DIV+GAP_CYCLES: done=1 for exactly one cycle, busy=0, FSM=IDLE.
- Back-to-back frames:
  - start held high is accepted on the first cycle busy=0.
  - The next cs_n fall is therefore one cycle after done.
- sclk never glitches; exactly 32 transitions per frame.
- mosi is stable across every rising edge.
- No address checking: any addr 0..127 is transmitted as given.
- Counters: divider 8 bits, bit counter 5 bits. Neither wraps within a frame; both clear on return to IDLE.

Optional Feature:
- Macro: SPI_CTRL_READBACK_EN.
- When defined:
  - Adds ports miso (input, 1 bit), rnw (input, 1 bit, latched on accept) and rdata (output, 8 bits, reset 0).
  - Frame bit 15 becomes ~rnw.
  - miso is sampled on sclk rising edges k=8..15 (MSB first) into an 8-bit shift register.
  - rdata updates on the same edge done asserts, and only when rnw was 1; otherwise rdata holds.
- When undefined: these ports are absent, frame bit 15 is always 1, and no miso logic exists.

Test Plan:
- Reset idle: assert rst_n=0, release, run 20 cycles with start=0 -> cs_n=1, sclk=0, mosi=0, busy=0, done=0 throughout.
- Single write, CLK_DIV=4, GAP_CYCLES=4, addr=3, wdata=0xA5:
  - bits captured on sclk rises = 0x83A5, 16 rises.
  - cs_n low for 132 cycles.
  - done pulses 136 cycles after accept.
- Start while busy: second start pulse with addr=5, wdata=0x11 at cycle 50 of a frame -> ignored; only one frame is sent and done pulses once.
- Back-to-back: start held high with addr=1/wdata=0xFF, then addr=2/wdata=0x00 -> frames 0x81FF, 0x8200; cs_n high for exactly GAP_CYCLES+1 cycles between them.
- Reset mid-frame: assert rst_n=0 after the 7th sclk rise -> outputs go to idle values immediately. A following frame with addr=4/wdata=0x3C transmits 0x843C cleanly.
- Readback (SPI_CTRL_READBACK_EN defined): rnw=1, addr=2, peripheral model returns 0x5A on miso -> frame bit15=0 and rdata=0x5A when done asserts.
